addr_unit: RTL and testbench

Parametrised address unit for the rudimentary machine: owns PC, IR and RDIR, drives the single memory address bus, and sequences instruction fetch and the data-access cycle itself instead of relying on per-cycle control strobes. It sits between the synchronous RAM, the register bank (`base_in`) and the control unit. It adds three things to the fixed 8/16-bit datapath:
- width generality
- a fetch/decode/data state machine with an exec handshake
- conditional branch target loading

---
 rtl/addr_unit.sv | 101 ++++++++++
 tb/tb_addr_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/addr_unit.sv
// addr_unit: PC/IR/RDIR owner with fetch/decode/data FSM; define ADDR_UNIT_OVF_TRAP_EN to trap RDIR carry-out into err
module addr_unit #(
    parameter int unsigned   AW       = 8,
    parameter int unsigned   DW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          run,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [DW-1:0] mem_data,
    input  logic [DW-1:0] base_in,
    output logic [DW-1:0] ir,
    output logic          ir_valid,
    input  logic          exec_valid,
    input  logic [1:0]    exec_op,
    input  logic          cond,
    output logic          data_phase,
    output logic [AW-1:0] pc,
    output logic          err
);
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_DATA} state_t;
    state_t        state_q, state_d, boundary;
    logic [AW-1:0] pc_q, pc_d, rdir_q, rdir_d;
    logic [DW-1:0] ir_q, ir_d;
    logic          unused_base;
`ifdef ADDR_UNIT_OVF_TRAP_EN
    logic [AW:0]   sum;
    logic          err_q, err_d;
    assign sum = {1'b0, base_in[AW-1:0]} + {1'b0, ir_q[AW-1:0]};
    assign err = err_q;
`else
    logic [AW-1:0] sum;
    assign sum = base_in[AW-1:0] + ir_q[AW-1:0];
    assign err = 1'b0;
`endif
    assign unused_base = ^base_in;
    assign boundary    = run ? S_FETCH : S_IDLE;
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        rdir_d  = rdir_q;
`ifdef ADDR_UNIT_OVF_TRAP_EN
        err_d   = err_q;
`endif
        case (state_q)
            S_IDLE:   state_d = boundary;
            S_FETCH: begin
                pc_d    = pc_q + 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                ir_d    = mem_data;
                state_d = S_DECODE;
            end
            S_DECODE: if (exec_valid) begin
                state_d = boundary;
                if (exec_op == 2'b10 && cond) pc_d = ir_q[AW-1:0];
                if (exec_op == 2'b01) begin
                    rdir_d = sum[AW-1:0];
`ifdef ADDR_UNIT_OVF_TRAP_EN
                    // a carry out traps: flag it and drop the data cycle
                    if (sum[AW]) err_d = 1'b1;
                    else state_d = S_DATA;
`else
                    state_d = S_DATA;
`endif
                end
            end
            S_DATA:   state_d = boundary;
            default:  state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            rdir_q  <= '0;
`ifdef ADDR_UNIT_OVF_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            rdir_q  <= rdir_d;
`ifdef ADDR_UNIT_OVF_TRAP_EN
            err_q   <= err_d;
`endif
        end
    end
    assign mem_rd     = state_q == S_FETCH;
    assign ir_valid   = state_q == S_DECODE;
    assign data_phase = state_q == S_DATA;
    assign mem_addr   = data_phase ? rdir_q : pc_q;
    assign pc         = pc_q;
    assign ir         = ir_q;
endmodule

// File: tb/tb_addr_unit.sv
// tb_addr_unit: directed vector bench for addr_unit in default and AW=12/DW=24 configurations
module tb_addr_unit;
    logic        clk, rst, run, mem_rd, ir_valid, exec_valid, cond, data_phase, err;
    logic [7:0]  mem_addr, pc;
    logic [15:0] mem_data, base_in, ir;
    logic [1:0]  exec_op;
    logic [15:0] ram [256];

    logic        run2, mem_rd2, ir_valid2, exec_valid2, cond2, data_phase2, err2;
    logic [11:0] mem_addr2, pc2;
    logic [23:0] mem_data2, base_in2, ir2;
    logic [1:0]  exec_op2;
    logic [23:0] ram2 [4096];

    int n_chk = 0;
    int n_fail = 0;

    addr_unit dut (
        .clk(clk), .rst(rst), .run(run), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_data(mem_data), .base_in(base_in), .ir(ir), .ir_valid(ir_valid),
        .exec_valid(exec_valid), .exec_op(exec_op), .cond(cond),
        .data_phase(data_phase), .pc(pc), .err(err)
    );

    addr_unit #(.AW(12), .DW(24), .RESET_PC(12'h100)) dut2 (
        .clk(clk), .rst(rst), .run(run2), .mem_addr(mem_addr2), .mem_rd(mem_rd2),
        .mem_data(mem_data2), .base_in(base_in2), .ir(ir2), .ir_valid(ir_valid2),
        .exec_valid(exec_valid2), .exec_op(exec_op2), .cond(cond2),
        .data_phase(data_phase2), .pc(pc2), .err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_data  <= ram[mem_addr];
        mem_data2 <= ram2[mem_addr2];
    end

    typedef struct {
        logic        run, ev;
        logic [1:0]  op;
        logic        cond;
        logic [15:0] base;
        logic [7:0]  addr;
        logic        rd, irv, dp;
        logic [7:0]  pc;
        logic [15:0] ir;
        logic        err;
    } vec_t;
    vec_t tbl [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic e, input logic [1:0] o, input logic c, input logic [15:0] b);
        run = r; exec_valid = e; exec_op = o; cond = c; base_in = b;
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, " addr"}, 32'(mem_addr), 32'h00);
        chk({nm, " pc"}, 32'(pc), 32'h00);
        chk({nm, " ir"}, 32'(ir), 32'h0);
        chk({nm, " strobes"}, {29'b0, mem_rd, ir_valid, data_phase}, 32'b0);
        chk({nm, " err"}, 32'(err), 32'b0);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 16'h0);
        run2 = 1'b0; exec_valid2 = 1'b0; exec_op2 = 2'b00; cond2 = 1'b0; base_in2 = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = '0;
        for (int i = 0; i < 4096; i++) ram2[i] = '0;
        ram[8'h00] = 16'h1234;
        ram[8'h01] = 16'h0005;
        ram[8'h02] = 16'h0040;
        ram[8'h40] = 16'h0050;
        ram[8'h41] = 16'h0020;
        ram2[12'h100] = 24'h7FF123;

        // run, ev, op, cond, base | addr, rd, irv, dp, pc, ir, err
        tbl.push_back('{1'b1,1'b0,2'b00,1'b0,16'h0000, 8'h00,1'b0,1'b0,1'b0,8'h00,16'h0000,1'b0});
        tbl.push_back('{1'b1,1'b0,2'b00,1'b0,16'h0000, 8'h00,1'b1,1'b0,1'b0,8'h00,16'h0000,1'b0});
        tbl.push_back('{1'b1,1'b0,2'b00,1'b0,16'h0000, 8'h01,1'b0,1'b0,1'b0,8'h01,16'h0000,1'b0});
        tbl.push_back('{1'b1,1'b1,2'b00,1'b0,16'h0000, 8'h01,1'b0,1'b1,1'b0,8'h01,16'h1234,1'b0});
        tbl.push_back('{1'b1,1'b0,2'b00,1'b0,16'h0000, 8'h01,1'b1,1'b0,1'b0,8'h01,16'h1234,1'b0});
        tbl.push_back('{1'b1,1'b0,2'b00,1'b0,16'h0000, 8'h02,1'b0,1'b0,1'b0,8'h02,16'h1234,1'b0});
        tbl.push_back('{1'b1,1'b1,2'b01,1'b0,16'h0010, 8'h02,1'b0,1'b1,1'b0,8'h02,16'h0005,1'b0});
        tbl.push_back('{1'b1,1'b0,2'b00,1'b0,16'h0010, 8'h15,1'b0,1'b0,1'b1,8'h02,16'h0005,1'b0});
        tbl.push_back('{1'b1,1'b0,2'b00,1'b0,16'h0000, 8'h02,1'b1,1'b0,1'b0,8'h02,16'h0005,1'b0});
        tbl.push_back('{1'b1,1'b0,2'b00,1'b0,16'h0000, 8'h03,1'b0,1'b0,1'b0,8'h03,16'h0005,1'b0});
        tbl.push_back('{1'b1,1'b1,2'b10,1'b1,16'h0000, 8'h03,1'b0,1'b1,1'b0,8'h03,16'h0040,1'b0});
        tbl.push_back('{1'b1,1'b1,2'b10,1'b1,16'h0000, 8'h40,1'b1,1'b0,1'b0,8'h40,16'h0040,1'b0});
        tbl.push_back('{1'b1,1'b1,2'b10,1'b1,16'h0000, 8'h41,1'b0,1'b0,1'b0,8'h41,16'h0040,1'b0});
        tbl.push_back('{1'b1,1'b0,2'b10,1'b1,16'h0000, 8'h41,1'b0,1'b1,1'b0,8'h41,16'h0050,1'b0});
        tbl.push_back('{1'b1,1'b1,2'b10,1'b0,16'h0000, 8'h41,1'b0,1'b1,1'b0,8'h41,16'h0050,1'b0});
        tbl.push_back('{1'b1,1'b0,2'b00,1'b0,16'h0000, 8'h41,1'b1,1'b0,1'b0,8'h41,16'h0050,1'b0});
        tbl.push_back('{1'b1,1'b0,2'b00,1'b0,16'h0000, 8'h42,1'b0,1'b0,1'b0,8'h42,16'h0050,1'b0});
        tbl.push_back('{1'b1,1'b1,2'b01,1'b0,16'h00F0, 8'h42,1'b0,1'b1,1'b0,8'h42,16'h0020,1'b0});
`ifdef ADDR_UNIT_OVF_TRAP_EN
        tbl.push_back('{1'b1,1'b0,2'b00,1'b0,16'h00F0, 8'h42,1'b1,1'b0,1'b0,8'h42,16'h0020,1'b1});
        tbl.push_back('{1'b1,1'b0,2'b00,1'b0,16'h00F0, 8'h43,1'b0,1'b0,1'b0,8'h43,16'h0020,1'b1});
`else
        tbl.push_back('{1'b1,1'b0,2'b00,1'b0,16'h00F0, 8'h10,1'b0,1'b0,1'b1,8'h42,16'h0020,1'b0});
        tbl.push_back('{1'b1,1'b0,2'b00,1'b0,16'h00F0, 8'h42,1'b1,1'b0,1'b0,8'h42,16'h0020,1'b0});
`endif

        do_reset();
        chk_reset("reset");
        chk("reset dut2 addr", 32'(mem_addr2), 32'h100);
        chk("reset dut2 pc", 32'(pc2), 32'h100);

        foreach (tbl[i]) begin
            drive(tbl[i].run, tbl[i].ev, tbl[i].op, tbl[i].cond, tbl[i].base);
            chk($sformatf("row%0d addr", i), 32'(mem_addr), 32'(tbl[i].addr));
            chk($sformatf("row%0d rd/irv/dp", i), {29'b0, mem_rd, ir_valid, data_phase},
                {29'b0, tbl[i].rd, tbl[i].irv, tbl[i].dp});
            chk($sformatf("row%0d pc", i), 32'(pc), 32'(tbl[i].pc));
            chk($sformatf("row%0d ir", i), 32'(ir), 32'(tbl[i].ir));
            chk($sformatf("row%0d err", i), 32'(err), 32'(tbl[i].err));
            tick();
        end

        // PC wrap: branch to 0xFF, fetch there, PC rolls to 0; op 11 acts as NEXT
        ram[8'h00] = 16'h00FF;
        do_reset();
        drive(1'b1, 1'b0, 2'b00, 1'b0, 16'h0);
        repeat (3) tick();
        drive(1'b1, 1'b1, 2'b10, 1'b1, 16'h0);
        chk("wrap decode", 32'(ir_valid), 32'b1);
        tick();
        drive(1'b1, 1'b0, 2'b00, 1'b0, 16'h0);
        chk("wrap fetch addr", 32'(mem_addr), 32'hFF);
        chk("wrap fetch rd", 32'(mem_rd), 32'b1);
        tick();
        chk("wrap pc", 32'(pc), 32'h00);
        tick();
        drive(1'b1, 1'b1, 2'b11, 1'b1, 16'h0);
        tick();
        drive(1'b1, 1'b0, 2'b00, 1'b0, 16'h0);
        chk("op11 fetch addr", 32'(mem_addr), 32'h00);
        chk("op11 fetch rd", 32'(mem_rd), 32'b1);

        // run dropped in DECODE: finish the instruction, then park in IDLE
        ram[8'h00] = 16'h1234;
        do_reset();
        drive(1'b1, 1'b0, 2'b00, 1'b0, 16'h0);
        repeat (3) tick();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 16'h0);
        tick();
        chk("rundrop hold decode", 32'(ir_valid), 32'b1);
        drive(1'b0, 1'b1, 2'b00, 1'b0, 16'h0);
        tick();
        drive(1'b0, 1'b0, 2'b00, 1'b0, 16'h0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rundrop idle%0d rd/irv", k), {30'b0, mem_rd, ir_valid}, 32'b0);
            chk($sformatf("rundrop idle%0d addr", k), 32'(mem_addr), 32'h01);
            tick();
        end

        // rst during DATA
        ram[8'h00] = 16'h0005;
        do_reset();
        drive(1'b1, 1'b0, 2'b00, 1'b0, 16'h0010);
        repeat (3) tick();
        drive(1'b1, 1'b1, 2'b01, 1'b0, 16'h0010);
        tick();
        drive(1'b1, 1'b0, 2'b00, 1'b0, 16'h0010);
        chk("rstdata dp", 32'(data_phase), 32'b1);
        chk("rstdata addr", 32'(mem_addr), 32'h15);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset("rstdata after");

        // wide instance: AW=12, DW=24, RESET_PC=0x100
        do_reset();
        run2 = 1'b1;
        base_in2 = 24'hFFF010;
        chk("w idle addr", 32'(mem_addr2), 32'h100);
        tick();
        chk("w fetch addr", 32'(mem_addr2), 32'h100);
        chk("w fetch rd", 32'(mem_rd2), 32'b1);
        tick();
        chk("w wait pc", 32'(pc2), 32'h101);
        tick();
        chk("w decode ir", 32'(ir2), 32'h7FF123);
        exec_valid2 = 1'b1; exec_op2 = 2'b01;
        tick();
        exec_valid2 = 1'b0; exec_op2 = 2'b00;
        chk("w data dp", 32'(data_phase2), 32'b1);
        chk("w data addr", 32'(mem_addr2), 32'h133);
        tick();
        chk("w next fetch addr", 32'(mem_addr2), 32'h101);
        chk("w err", 32'(err2), 32'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
